// File: rtl/regfile_arb_pkg.sv
// Shared widths, FSM encoding and request record for the register-file
// write arbiter and its secondary-requester FIFO.
package regfile_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int ENTRY_W    = REG_ADDR_W + DATA_W;

    // Arbitration FSM encoding.
    localparam logic [0:0] NORMAL  = 1'b0;
    localparam logic [0:0] FORCE_B = 1'b1;

    // One write request: destination register and data, packed as {reg,data}.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wr_req_t;

endpackage

// File: rtl/regfile_arb_fifo.sv
// Small synchronous FIFO buffering requester-B writes. No bypass path:
// a pushed entry becomes visible at the head on the following cycle.
module regfile_arb_fifo
    import regfile_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push_en;
    logic             pop_en;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage, written at the tail on an accepted push.
    // NOTE: storage is deliberately not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register-file write port between the pipeline writeback
// (requester A, highest priority) and a buffered multi-cycle unit
// (requester B). A starvation counter forces one B grant after B has lost
// MAX_WAIT consecutive arbitrations. The winner is registered onto the port.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  AWrite,
    input  logic [REG_ADDR_W-1:0] AReg,
    input  logic [DATA_W-1:0]     AData,
    output logic                  AStall,
    input  logic                  BValid,
    input  logic [REG_ADDR_W-1:0] BReg,
    input  logic [DATA_W-1:0]     BData,
    output logic                  BReady,
    output logic                  BPending,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0]     WriteData
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [0:0]        state;
    logic [0:0]        state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_next;

    wr_req_t a_req;
    wr_req_t b_req;
    wr_req_t b_head;
    wr_req_t winner;
    logic    fifo_full;
    logic    fifo_empty;
    logic    b_push;
    logic    grant_a;
    logic    grant_b;
    logic    do_write;

    assign a_req = '{addr: AReg, data: AData};
    assign b_req = '{addr: BReg, data: BData};

    assign BReady   = !fifo_full;
    assign BPending = !fifo_empty;
    assign AStall   = AWrite && (state == FORCE_B);
    assign b_push   = BValid && BReady;

    regfile_arb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (Clk),
        .rst       (Reset),
        .push      (b_push),
        .push_data (b_req),
        .pop       (grant_b),
        .head      (b_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Winner selection: forced B, else A, else buffered B, else nobody.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == FORCE_B) begin
            grant_b = !fifo_empty;
        end else if (AWrite) begin
            grant_a = 1'b1;
        end else begin
            grant_b = !fifo_empty;
        end
        winner   = grant_b ? b_head : a_req;
        do_write = (grant_a || grant_b) && (winner.addr != '0);
    end

    // Starvation count and FSM next state.
    always_comb begin
        wait_cnt_next = wait_cnt;
        state_next    = state;
        if (fifo_empty || grant_b) begin
            wait_cnt_next = '0;
        end else if (grant_a && (wait_cnt != WAIT_MAX)) begin
            wait_cnt_next = wait_cnt + 1'b1;
        end
        case (state)
            NORMAL:  if (wait_cnt_next == WAIT_MAX) state_next = FORCE_B;
            default: state_next = NORMAL;
        endcase
    end

    // FSM state and starvation counter registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= NORMAL;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Register-file port; address and data hold when nothing is written.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            RegWrite <= do_write;
            if (do_write) begin
                WriteRegister <= winner.addr;
                WriteData     <= winner.data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios with
// literal expectations plus randomized traffic against a queue-based model.
module tb_regfile_write_arbiter;

    localparam int DEPTH = 4;
    localparam int MAXW  = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        AWrite = 1'b0;
    logic [4:0]  AReg = '0;
    logic [31:0] AData = '0;
    logic        AStall;
    logic        BValid = 1'b0;
    logic [4:0]  BReg = '0;
    logic [31:0] BData = '0;
    logic        BReady;
    logic        BPending;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;

    always #5 Clk = ~Clk;

    regfile_write_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .MAX_WAIT   (MAXW)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .AWrite        (AWrite),
        .AReg          (AReg),
        .AData         (AData),
        .AStall        (AStall),
        .BValid        (BValid),
        .BReg          (BReg),
        .BData         (BData),
        .BReady        (BReady),
        .BPending      (BPending),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData)
    );

    int tests  = 0;
    int failed = 0;

    // Reference model: queue of buffered B requests, count of consecutive
    // B losses, and a one-shot force flag.
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    int          starve;
    bit          force_b;
    logic        m_rw;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;
    bit          m_data_known;
    logic [4:0]  b_order[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        starve       = 0;
        force_b      = 0;
        m_rw         = 1'b0;
        m_wreg       = '0;
        m_wdata      = '0;
        m_data_known = 1;
    endtask

    // One clock cycle: check combinational outputs mid-cycle, advance the
    // model, then check the registered port just after the rising edge.
    task automatic tick(input string tag);
        bit   win_a;
        bit   win_b;
        bit   had;
        bit   ready;
        ent_t w;
        @(negedge Clk);
        ready = (q.size() < DEPTH);
        had   = (q.size() != 0);
        check({tag, ".astall"},   AStall,   AWrite && force_b);
        check({tag, ".bready"},   BReady,   ready);
        check({tag, ".bpending"}, BPending, had);
        win_a = 0;
        win_b = 0;
        if (force_b)     win_b = had;
        else if (AWrite) win_a = 1;
        else             win_b = had;
        if (win_b) w = q.pop_front();
        else       w = '{AReg, AData};
        if (BValid && ready) q.push_back('{BReg, BData});
        if (!had || win_b)                  starve = 0;
        else if (win_a && starve < MAXW)    starve++;
        force_b = !force_b && (starve == MAXW);
        m_rw = (win_a || win_b) && (w.r != 0);
        if (m_rw) begin
            m_wreg       = w.r;
            m_wdata      = w.d;
            m_data_known = 1;
        end else if (win_a || win_b) begin
            m_data_known = 0;
        end
        @(posedge Clk);
        #1;
        check({tag, ".regwrite"}, RegWrite, m_rw);
        if (m_data_known) begin
            check({tag, ".wreg"},  WriteRegister, m_wreg);
            check({tag, ".wdata"}, WriteData,     m_wdata);
        end
    endtask

    initial begin
        bit rdy;
        bit accepted5;

        // Reset state
        model_reset();
        #12;
        check("reset.regwrite", RegWrite, 0);
        check("reset.wreg",     WriteRegister, 0);
        check("reset.wdata",    WriteData, 0);
        check("reset.bready",   BReady, 1);
        check("reset.bpending", BPending, 0);
        check("reset.astall",   AStall, 0);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        // A-only: granted on the first edge with a request present
        AWrite = 1; AReg = 5; AData = 32'hDEAD_BEEF;
        tick("aonly");
        check("aonly.rw",    RegWrite, 1);
        check("aonly.reg",   WriteRegister, 5);
        check("aonly.data",  WriteData, 32'hDEAD_BEEF);
        AWrite = 0;
        tick("aonly.idle");
        check("aonly.idle_rw",   RegWrite, 0);
        check("aonly.hold_reg",  WriteRegister, 5);
        check("aonly.hold_data", WriteData, 32'hDEAD_BEEF);

        // B-only: two cycles from acceptance to the port
        BValid = 1; BReg = 7; BData = 32'h1234_5678;
        tick("bonly.push");
        BValid = 0;
        check("bonly.pending", BPending, 1);
        check("bonly.no_bypass", RegWrite, 0);
        tick("bonly.pop");
        check("bonly.rw",      RegWrite, 1);
        check("bonly.reg",     WriteRegister, 7);
        check("bonly.data",    WriteData, 32'h1234_5678);
        check("bonly.drained", BPending, 0);

        // Register 0: handshakes complete without a write
        AWrite = 1; AReg = 0; AData = 32'hFFFF_FFFF;
        tick("zero.a");
        check("zero.a_rw",    RegWrite, 0);
        check("zero.a_stall", AStall, 0);
        AWrite = 0;
        BValid = 1; BReg = 0; BData = 32'h0BAD_0BAD;
        tick("zero.bpush");
        BValid = 0;
        check("zero.b_pending", BPending, 1);
        tick("zero.bpop");
        check("zero.b_drained", BPending, 0);
        check("zero.b_rw",      RegWrite, 0);

        // Starvation: A wins MAX_WAIT times, then one forced B grant
        BValid = 1; BReg = 9; BData = 32'h0000_9999;
        tick("starve.push");
        BValid = 0;
        AWrite = 1; AReg = 3; AData = 32'h0000_3333;
        for (int i = 0; i < MAXW; i++) begin
            tick("starve.awin");
            check("starve.a_rw",  RegWrite, 1);
            check("starve.a_reg", WriteRegister, 3);
        end
        #2;
        check("starve.stall_on", AStall, 1);
        tick("starve.force");
        check("starve.b_reg",  WriteRegister, 9);
        check("starve.b_data", WriteData, 32'h0000_9999);
        #2;
        check("starve.stall_off", AStall, 0);
        tick("starve.resume");
        check("starve.resume_reg", WriteRegister, 3);
        AWrite = 0;
        tick("starve.idle");

        // Full FIFO: four pushes behind a busy A, fifth waits for a pop
        AWrite = 1; AReg = 20; AData = 32'hA0A0_0000;
        for (int i = 1; i <= 4; i++) begin
            BValid = 1; BReg = 5'(i); BData = 32'h100 + i;
            tick("full.push");
        end
        BReg = 5; BData = 32'h105;
        #2;
        check("full.bready_low", BReady, 0);
        b_order.delete();
        accepted5 = 0;
        for (int c = 0; c < 40 && !accepted5; c++) begin
            rdy = (q.size() < DEPTH);
            tick("full.wait");
            if (RegWrite && WriteRegister != 20) b_order.push_back(WriteRegister);
            if (rdy) begin
                accepted5 = 1;
                BValid    = 0;
                check("full.fifth_after_pop", b_order.size() >= 1, 1);
            end
        end
        check("full.fifth_accepted", accepted5, 1);
        AWrite = 0;
        BValid = 0;
        for (int c = 0; c < 20; c++) begin
            tick("full.drain");
            if (RegWrite && WriteRegister != 20) b_order.push_back(WriteRegister);
        end
        check("full.write_count", b_order.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < b_order.size()) check("full.order", b_order[i], i + 1);
        end

        // Asynchronous reset with buffered entries
        AWrite = 1; AReg = 20; AData = 32'hC0C0_C0C0;
        for (int i = 0; i < 3; i++) begin
            BValid = 1; BReg = 5'(10 + i); BData = 32'hB000 + i;
            tick("rst.fill");
        end
        BValid = 0;
        check("rst.filled", BPending, 1);
        #3;
        Reset = 1'b1;
        model_reset();
        #1;
        check("rst.rw",       RegWrite, 0);
        check("rst.wreg",     WriteRegister, 0);
        check("rst.wdata",    WriteData, 0);
        check("rst.bpending", BPending, 0);
        check("rst.bready",   BReady, 1);
        AWrite = 0;
        check("rst.astall",   AStall, 0);
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            tick("rst.after");
            check("rst.no_write", RegWrite, 0);
        end

        // Randomized traffic; A is held while stalled
        for (int c = 0; c < 400; c++) begin
            if (!(AWrite && force_b)) begin
                AWrite = ($urandom_range(0, 99) < 60);
                AReg   = 5'($urandom_range(0, 31));
                AData  = $urandom;
            end
            BValid = ($urandom_range(0, 99) < 40);
            BReg   = 5'($urandom_range(0, 31));
            BData  = $urandom;
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
